// File: rtl/sum_operand_recover.sv
`default_nettype none
// ============================================================================
// Module   : sum_operand_recover
// Purpose  : Bit-serial inverse of a registered 2-operand adder. Given the
//            WIDTH+1-bit sum and one known WIDTH-bit operand, recovers the
//            other operand (sum - op) one bit per clock, LSB first, and flags
//            sums that no legal pair of WIDTH-bit operands could produce.
//            A saturating counter tallies flagged results for bring-up.
// Ports    : i_clk, i_rst (async, active-high)
//            i_in_valid / o_in_ready      : input handshake (ready only in IDLE)
//            i_sum [WIDTH:0], i_op [WIDTH-1:0] : adder sum and known operand
//            o_out_valid / i_out_ready    : output handshake (held until taken)
//            o_op [WIDTH-1:0]             : recovered operand
//            o_err                        : sum inconsistent with i_op
//            o_err_count [ERR_CNT_W-1:0]  : saturating count of o_err results
// Revision : 1.0 - initial release
// ============================================================================
module sum_operand_recover #(
  parameter int WIDTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH:0]       i_sum,
  input  logic [WIDTH-1:0]     i_op,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WIDTH-1:0]     o_op,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  // Bit counter must hold 0..WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH:0]     r_sum_sr;
  logic [WIDTH:0]     r_op_sr;
  logic [WIDTH-1:0]   r_diff_sr;   // low WIDTH difference bits, filled MSB-ward
  logic               r_borrow;
  logic [CNT_W-1:0]   r_bit_cnt;

  logic               w_s0;
  logic               w_o0;
  logic               w_diff_bit;
  logic               w_borrow_next;
  logic [WIDTH:0]     w_diff_full;
  logic               w_last_bit;
  logic               w_accept;
  logic               w_err_final;

  // Handshake flags come straight from the state register.
  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);

  assign w_accept = (r_state == S_IDLE) && i_in_valid;

  // One full-subtractor step on the current LSBs.
  assign w_s0          = r_sum_sr[0];
  assign w_o0          = r_op_sr[0];
  assign w_diff_bit    = w_s0 ^ w_o0 ^ r_borrow;
  assign w_borrow_next = (~w_s0 & w_o0) | (~(w_s0 ^ w_o0) & r_borrow);

  // On the final step the incoming bit is bit WIDTH and r_diff_sr already
  // holds bits WIDTH-1..0, so this concatenation is the complete difference.
  assign w_diff_full = {w_diff_bit, r_diff_sr};
  assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH));

  // A leftover borrow means sum < op; a set top bit means the difference
  // does not fit in WIDTH bits. Either way no legal operand exists.
  assign w_err_final = w_borrow_next | w_diff_full[WIDTH];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last_bit)  w_state_next = S_DONE;
      S_DONE:  if (i_out_ready) w_state_next = S_IDLE;
      default:                  w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum_sr    <= '0;
      r_op_sr     <= '0;
      r_diff_sr   <= '0;
      r_borrow    <= 1'b0;
      r_bit_cnt   <= '0;
      o_op        <= '0;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else if (w_accept) begin
      r_sum_sr  <= i_sum;
      r_op_sr   <= {1'b0, i_op};
      r_diff_sr <= '0;
      r_borrow  <= 1'b0;
      r_bit_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_sum_sr  <= {1'b0, r_sum_sr[WIDTH:1]};
      r_op_sr   <= {1'b0, r_op_sr[WIDTH:1]};
      r_diff_sr <= w_diff_full[WIDTH:1];
      r_borrow  <= w_borrow_next;
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_last_bit) begin
        o_op  <= w_diff_full[WIDTH-1:0];
        o_err <= w_err_final;
        if (w_err_final && (o_err_count != {ERR_CNT_W{1'b1}})) begin
          o_err_count <= o_err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sum_operand_recover.md
# sum_operand_recover

Bit-serial inverse of the registered 2-operand adder stage: takes a WIDTH+1-bit sum and one known WIDTH-bit operand, recovers the other operand as sum − operand, and flags results that no legal adder input could produce. It sits on the consumer side of the adder's registered result. It uses valid/ready handshakes on input and output, computes one bit per clock LSB-first, and keeps a saturating error count for bring-up diagnostics.

## Interface
- WIDTH, 2, operand width; sum width is WIDTH+1
- ERR_CNT_W, 8, width of saturating error counter
- i_clk  input  1  sole clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_in_valid  input  1  i_sum/i_op valid
- o_in_ready  output  1  block can accept; high only in IDLE
- i_sum  input  WIDTH+1  sum produced by adder
- i_op  input  WIDTH  known operand
- o_out_valid  output  1  result valid; held until accepted
- i_out_ready  input  1  downstream accepts result
- o_op  output  WIDTH  recovered operand
- o_err  output  1  sum inconsistent with i_op (negative or ≥ 2^WIDTH)
- o_err_count  output  ERR_CNT_W  saturating count of results with o_err=1

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE: o_in_ready=1. On i_in_valid=1, capture i_sum and i_op (zero-extended to WIDTH+1) into shift registers; clear the borrow; bit counter=0; go to SHIFT. Inputs changing after capture are ignored.
- SHIFT: each cycle, diff_bit = s0 ^ o0 ^ borrow and borrow' = (~s0 & o0) | (~(s0 ^ o0) & borrow), using the LSBs of the shifted registers. Shift diff_bit into the result register MSB-ward. After WIDTH+1 bits, go to DONE.
- Entry to DONE (same edge): o_op = diff[WIDTH-1:0]; o_err = final_borrow | diff[WIDTH]; o_out_valid=1. If o_err=1, o_err_count increments, saturating at 2^ERR_CNT_W−1.
- DONE: o_op, o_err and o_out_valid are held stable while i_out_ready=0. i_in_valid is ignored. When i_out_ready=1, go to IDLE and o_out_valid falls.
- o_op and o_err keep their last values after handoff, until the next DONE entry.
- Arithmetic is modulo 2^(WIDTH+1). The error condition covers every case with no valid inverse.
- Reset at any time, including mid-SHIFT or in DONE: state goes to IDLE, all registers clear, and in-flight data is discarded without being counted.

## Timing
- Reset values: o_in_ready=1, o_out_valid=0, o_op=0, o_err=0, o_err_count=0.
- Accept edge E0 is the edge where i_in_valid & o_in_ready are both high.
- SHIFT edges are E1..E(WIDTH+1). o_out_valid is high after edge E(WIDTH+1): 3 cycles after E0 for WIDTH=2.
- o_err_count updates on the same edge that o_out_valid rises.
- Handoff edge: o_out_valid=1 & i_out_ready=1. o_in_ready is high the following cycle.
- Input acceptance never overlaps SHIFT or DONE.
- Minimum spacing between acceptances is WIDTH+3 cycles, with i_out_ready held at 1.
- o_in_ready and o_out_valid are decoded from state registers only; there is no combinational path from any input.

## Test plan
- Reset, then i_sum=3'b101, i_op=2'b11 (WIDTH=2). Required: o_out_valid high 3 cycles after accept, o_op=2'b10, o_err=0, o_err_count=0.
- i_sum=3'b001, i_op=2'b11 (negative result). Required: o_err=1, o_op=2'b10 (mod wrap), o_err_count=1.
- i_sum=3'b111, i_op=2'b10 (diff=5 ≥ 4). Required: o_err=1, o_op=2'b01, o_err_count increments.
- Backpressure: hold i_out_ready=0 for 10 cycles after valid, toggling i_in_valid, i_sum and i_op meanwhile. Required: o_op, o_err and o_out_valid stay constant and o_in_ready=0. After i_out_ready=1: one handoff, then o_in_ready=1 on the next cycle.
- Assert i_rst during the second SHIFT cycle. Required: all outputs at reset values immediately, o_err_count unchanged from 0, next transaction correct.
- Sweep all 16 (a,b) pairs through a reference sum = a+b with i_op=b. Required: o_op=a and o_err=0 for every pair. Then, with ERR_CNT_W=2, apply 5 erroring inputs. Required: o_err_count saturates at 3.
